// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, bundle
// field bounds, PC arithmetic constants and the reset-PC default.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  localparam int BUNDLE_W  = 64;
  localparam int NEXTPC_LO = 0;
  localparam int NEXTPC_HI = 31;
  localparam int INSTR_LO  = 32;
  localparam int INSTR_HI  = 63;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Branch targets are word addresses; the two byte-offset bits are dropped.
  function automatic logic [0:31] word_align(input logic [0:31] a);
    return {a[0:29], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_perf_cnt.sv
// Delivered-instruction and bubble counters for the fetch stage; both wrap
// modulo 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_inc_i,
  input  logic        bubble_inc_i,
  output logic [0:31] fetch_count_o,
  output logic [0:31] bubble_count_o
);

  logic [0:31] fetch_q, fetch_d;
  logic [0:31] bubble_q, bubble_d;

  always_comb begin
    fetch_d  = fetch_q  + (fetch_inc_i  ? 32'd1 : 32'd0);
    bubble_d = bubble_q + (bubble_inc_i ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q  <= '0;
      bubble_q <= '0;
    end else begin
      fetch_q  <= fetch_d;
      bubble_q <= bubble_d;
    end
  end

  assign fetch_count_o  = fetch_q;
  assign bubble_count_o = bubble_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem fetches
// and drives the IF/ID bundle and flush. IF_FETCH_PERF_CNT_EN adds perf counters.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          WIDTH    = BUNDLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [0:31]      redirect_pc,
  output logic             imem_req,
  output logic [0:31]      imem_addr,
  input  logic             imem_rdy,
  input  logic [0:31]      imem_data,
  output logic [0:WIDTH-1] out,
  output logic             flush
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [0:31]      fetch_count,
  output logic [0:31]      bubble_count
`endif
);

  if (WIDTH != BUNDLE_W) begin : g_width_chk
    $error("if_fetch_stage: WIDTH must be 64");
  end

  fetch_state_e     state_q, state_d;
  logic [0:31]      pc_q, pc_d;
  logic [0:31]      tgt_q, tgt_d;
  logic [0:31]      hold_q, hold_d;
  logic [0:WIDTH-1] out_q, out_d;
  logic             flush_q, flush_d;

  logic        deliver;
  logic        bubble;
  logic [0:31] pc_plus4;
  logic [0:31] redir_tgt;
  logic [0:31] deliver_instr;

  assign pc_plus4      = pc_q + PC_INC;
  assign redir_tgt     = word_align(redirect_pc);
  assign deliver_instr = (state_q == ST_HOLD) ? hold_q : imem_data;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    out_d   = out_q;
    flush_d = flush_q;
    deliver = 1'b0;
    bubble  = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;

      ST_FETCH: begin
        if (redirect) begin
          bubble = 1'b1;
          if (imem_rdy) begin
            pc_d = redir_tgt;
          end else begin
            // Request already on the bus: let it finish, then squash it.
            tgt_d   = redir_tgt;
            state_d = ST_DROP;
          end
        end else if (imem_rdy) begin
          if (!stall) begin
            deliver = 1'b1;
          end else begin
            hold_d  = imem_data;
            state_d = ST_HOLD;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          bubble  = 1'b1;
          pc_d    = redir_tgt;
          state_d = ST_FETCH;
        end else if (!stall) begin
          deliver = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DROP: begin
        bubble = 1'b1;
        if (imem_rdy) begin
          pc_d    = redirect ? redir_tgt : tgt_q;
          state_d = ST_FETCH;
        end else if (redirect) begin
          tgt_d = redir_tgt;
        end
      end

      default: state_d = ST_START;
    endcase

    if (deliver) begin
      out_d[NEXTPC_LO:NEXTPC_HI] = pc_plus4;
      out_d[INSTR_LO:INSTR_HI]   = deliver_instr;
      flush_d                    = 1'b0;
      pc_d                       = pc_plus4;
    end
    if (bubble) begin
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      flush_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      flush_q <= flush_d;
    end
  end

  // Dropping req while reset is high abandons any in-flight transfer at once.
  assign imem_req  = ((state_q == ST_FETCH) || (state_q == ST_DROP)) && !reset;
  assign imem_addr = pc_q;
  assign out       = out_q;
  assign flush     = flush_q;

`ifdef IF_FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf_cnt (
    .clk            (clk),
    .reset          (reset),
    .fetch_inc_i    (deliver && !reset),
    .bubble_inc_i   (bubble && !reset),
    .fetch_count_o  (fetch_count),
    .bubble_count_o (bubble_count)
  );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_rdy;
  logic [0:31] redirect_pc, imem_data;
  logic        imem_req, flush;
  logic [0:31] imem_addr;
  logic [0:63] out;

  int checks = 0;
  int errors = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .out         (out),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  // Reference model: where IF/ID stands and what fetch is pending.
  logic        m_start;   // first cycle after reset, nothing requested
  logic        m_held_v;  // a fetched word is parked waiting for stall to drop
  logic        m_drop;    // in-flight fetch belongs to a squashed path
  logic [31:0] m_pc, m_tgt, m_held;
  logic [63:0] m_out;
  logic        m_flush;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  function automatic logic [97:0] exp_vec();
    return {(!m_start && !m_held_v), m_pc, m_out, m_flush};
  endfunction

  task automatic model_reset();
    m_start = 1'b1; m_held_v = 1'b0; m_drop = 1'b0;
    m_pc = 32'h0; m_tgt = 32'h0; m_held = 32'h0;
    m_out = 64'h0; m_flush = 1'b1;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc,
                            input logic rdy);
    logic [31:0] t;
    t = rpc & 32'hFFFF_FFFC;
    if (m_start) begin
      m_start = 1'b0;
    end else if (m_drop) begin
      m_flush = 1'b1;
      if (rd) m_tgt = t;
      if (rdy) begin m_pc = m_tgt; m_drop = 1'b0; end
    end else if (rd) begin
      m_flush = 1'b1;
      if (m_held_v) begin m_held_v = 1'b0; m_pc = t; end
      else if (rdy) m_pc = t;
      else begin m_drop = 1'b1; m_tgt = t; end
    end else if (m_held_v) begin
      if (!st) begin
        m_out = {m_pc + 32'd4, m_held}; m_flush = 1'b0;
        m_pc = m_pc + 32'd4; m_held_v = 1'b0;
      end
    end else if (rdy) begin
      if (st) begin m_held = mem(m_pc); m_held_v = 1'b1; end
      else begin
        m_out = {m_pc + 32'd4, mem(m_pc)}; m_flush = 1'b0;
        m_pc = m_pc + 32'd4;
      end
    end else if (!st) begin
      m_flush = 1'b1;
    end
  endtask

  // One clock: apply inputs, memory answers for the DUT's current address.
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy);
    stall = st; redirect = rd; redirect_pc = rpc; imem_rdy = rdy;
    imem_data = mem(imem_addr);
    model_step(st, rd, rpc, rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b0;
    redirect_pc = '0; imem_data = '0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_rdy = 1'b0;
    redirect_pc = '0; imem_data = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", imem_req); end
    checks++;
    reset = 1'b1; #1;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_abort: req=%b want 0", imem_req); end
    checks++;
    @(posedge clk); #1;
    model_reset();
    if (out !== 64'h0) begin errors++; $display("FAIL rst_out: got %h want 0", out); end
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL rst_flush: got %b want 1", flush); end
    checks++;
    reset = 1'b0; #1;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_start: req=%b addr=%h want 0/0", imem_req, imem_addr);
    end
    checks++;
  endtask

  task automatic test_zero_wait();
    do_reset();
    drive(0, 0, 0, 1);
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || flush !== 1'b1) begin
      errors++; $display("FAIL zw_c2: req=%b addr=%h flush=%b want 1/0/1", imem_req, imem_addr, flush);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'd4, 32'hAAAA_0000} || flush !== 1'b0 || imem_addr !== 32'd4) begin
      errors++; $display("FAIL zw_c3: out=%h flush=%b addr=%h", out, flush, imem_addr);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'd8, 32'hAAAA_0004} || flush !== 1'b0 || imem_addr !== 32'd8) begin
      errors++; $display("FAIL zw_c4: out=%h flush=%b addr=%h", out, flush, imem_addr);
    end
    checks++;
  endtask

  task automatic test_wait_states();
    logic [31:0] a;
    do_reset();
    drive(0, 0, 0, 0);
    a = 32'h0;
    for (int b = 0; b < 3; b++) begin
      for (int w = 0; w < 2; w++) begin
        drive(0, 0, 0, 0);
        if (flush !== 1'b1 || imem_addr !== a || imem_req !== 1'b1) begin
          errors++; $display("FAIL ws_wait: flush=%b addr=%h want 1/%h", flush, imem_addr, a);
        end
        checks++;
      end
      drive(0, 0, 0, 1);
      if (flush !== 1'b0 || out !== {a + 32'd4, mem(a)}) begin
        errors++; $display("FAIL ws_data: flush=%b out=%h want 0/%h", flush, out, {a + 32'd4, mem(a)});
      end
      checks++;
      a = a + 32'd4;
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      if (out !== {32'd4, 32'hAAAA_0000} || flush !== 1'b0) begin
        errors++; $display("FAIL st_frozen: out=%h flush=%b", out, flush);
      end
      checks++;
      drive(1, 0, 0, 1'($urandom_range(1)));
    end
    if (out !== {32'd4, 32'hAAAA_0000} || flush !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL st_frozen3: out=%h flush=%b req=%b", out, flush, imem_req);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'd8, 32'hAAAA_0004} || flush !== 1'b0 || imem_addr !== 32'd8) begin
      errors++; $display("FAIL st_release: out=%h flush=%b addr=%h", out, flush, imem_addr);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'd12, 32'hAAAA_0008} || flush !== 1'b0) begin
      errors++; $display("FAIL st_next: out=%h flush=%b", out, flush);
    end
    checks++;
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    drive(0, 1, 32'h0000_0100, 0);
    if (flush !== 1'b1 || imem_addr !== 32'h10 || imem_req !== 1'b1) begin
      errors++; $display("FAIL rd_drop1: flush=%b addr=%h req=%b", flush, imem_addr, imem_req);
    end
    checks++;
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    if (flush !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rd_target: flush=%b addr=%h want 1/100", flush, imem_addr);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'h104, 32'hAAAA_0100} || flush !== 1'b0) begin
      errors++; $display("FAIL rd_out: out=%h flush=%b", out, flush);
    end
    checks++;
  endtask

  task automatic test_redirect_stall_hold();
    do_reset();
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 1);
    if (imem_req !== 1'b0 || flush !== 1'b1) begin
      errors++; $display("FAIL rh_hold: req=%b flush=%b want 0/1", imem_req, flush);
    end
    checks++;
    drive(1, 1, 32'h0000_0203, 0);
    if (flush !== 1'b1 || imem_addr !== 32'h200 || imem_req !== 1'b1) begin
      errors++; $display("FAIL rh_redir: flush=%b addr=%h req=%b", flush, imem_addr, imem_req);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'h204, 32'hAAAA_0200} || flush !== 1'b0) begin
      errors++; $display("FAIL rh_out: out=%h flush=%b", out, flush);
    end
    checks++;
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 0, 0, 0);
    drive(0, 1, 32'hFFFF_FFFC, 1);
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wr_addr: got %h want fffffffc", imem_addr);
    end
    checks++;
    drive(0, 0, 0, 1);
    if (out !== {32'h0, 32'hAAA9_FFFC} || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wr_out: out=%h addr=%h", out, imem_addr);
    end
    checks++;
  endtask

  task automatic test_random();
    logic        st, rd, rdy;
    logic [31:0] rpc;
    logic [0:63] p_out;
    logic        p_flush;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
        continue;
      end
      st  = ($urandom_range(3) == 0);
      rd  = ($urandom_range(9) == 0);
      rdy = 1'($urandom_range(1));
      rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFB : $urandom;
      p_out = out; p_flush = flush;
      drive(st, rd, rpc, rdy);
      if ({imem_req, imem_addr, out, flush} !== exp_vec()) begin
        errors++;
        $display("FAIL rnd_model @%0d: req/addr/out/flush=%b %h %h %b want %h", i,
                 imem_req, imem_addr, out, flush, exp_vec());
      end
      checks++;
      if (st && !rd) begin
        if (out !== p_out || flush !== p_flush) begin
          errors++; $display("FAIL rnd_freeze @%0d: out=%h flush=%b was %h %b", i, out, flush, p_out, p_flush);
        end
        checks++;
      end
      if (flush === 1'b0) begin
        if (out[32:63] !== mem(out[0:31] - 32'd4)) begin
          errors++; $display("FAIL rnd_pair @%0d: out=%h", i, out);
        end
        checks++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_outstanding();
    test_redirect_stall_hold();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the IF/ID register. Owns the PC, issues one-outstanding-request fetches to instruction memory, and accepts taken-branch/jump redirects from ID and stall requests from the hazard unit. Each cycle it drives the 64-bit IF/ID bundle {nextPC, instruction} and the IF/ID `flush` control. IF/ID therefore loads a valid instruction, a bubble, or an unchanged copy of its current contents.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `WIDTH`, default 64: bundle width; fixed at 64. Other values are rejected at elaboration.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  ID is stalled. The IF/ID contents must not change.
- `redirect`  in  1  taken branch/jump resolved in ID.
- `redirect_pc`  in  [0:31]  redirect target, word-aligned.
- `imem_req`  out  1  fetch request outstanding.
- `imem_addr`  out  [0:31]  fetch address, equal to PC.
- `imem_rdy`  in  1  transfer completes in a cycle with `imem_req && imem_rdy`.
- `imem_data`  in  [0:31]  instruction word, valid when `imem_rdy`.
- `out`  out  [0:63]  bundle: [0:31] = fetch PC + 4; [32:63] = instruction. Registered.
- `flush`  out  1  IF/ID loads a bubble. Registered.

## Operation
- State machine, four states:
  - FETCH: `imem_req`=1.
  - HOLD: instruction captured but stalled; `imem_req`=0.
  - DROP: redirect pending while a request is outstanding; `imem_req`=1.
  - START: one cycle after reset; `imem_req`=0.
- Reset values: state START, PC = `RESET_PC`, `out` = 0, `flush` = 1, held-instruction register = 0.
- START goes to FETCH unconditionally.
- FETCH, completion, no redirect, `stall`=0:
  - `out` <= {PC+4, `imem_data`}, `flush` <= 0, PC <= PC+4.
  - Stay in FETCH; the next request issues the following cycle.
- FETCH, completion, no redirect, `stall`=1:
  - Capture `imem_data` into the hold register and go to HOLD.
  - `out` and `flush` are unchanged.
- FETCH, no completion, no redirect:
  - `stall`=0: `flush` <= 1.
  - `stall`=1: `out` and `flush` are unchanged.
- HOLD with `stall`=0: deliver the held word as {PC+4, held}, `flush` <= 0, PC <= PC+4, go to FETCH.
- HOLD with `stall`=1: remain in HOLD; outputs unchanged.
- Redirect rules. Redirect has priority over `stall`, and asserting both at once is legal.
  - Redirect without a completion in FETCH: latch `redirect_pc`, `flush` <= 1, go to DROP. `imem_addr` stays stable until `imem_rdy`.
  - Redirect in a completion cycle: discard the data, PC <= `redirect_pc`, `flush` <= 1, stay in FETCH.
  - Redirect in HOLD: discard the held word, PC <= `redirect_pc`, `flush` <= 1, go to FETCH.
  - In DROP, on `imem_rdy`: discard the data, PC <= latched target, go to FETCH.
  - A new redirect in DROP overwrites the latched target.
  - `flush` is 1 every DROP cycle.
- Address arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. Bits [30:31] of `redirect_pc` are ignored and forced to 0.
- `reset` mid-request aborts the request immediately. `imem_req` is 0 in the cycle after reset.

## Timing
- Zero-wait memory (`imem_rdy` in the first request cycle): one instruction per cycle.
- A word fetched in cycle N appears on `out` in cycle N+1 with `flush`=0.
- Redirect asserted in cycle N:
  - Earliest target fetch is cycle N+1, or the cycle after the outstanding `imem_rdy`.
  - Target instruction appears on `out` no earlier than N+2.
- `out` and `flush` never change in a cycle where `stall`=1 was sampled at the preceding edge without `redirect`.
- `imem_addr` is stable while `imem_req`=1 and no completion has occurred.

## Configuration
- `IF_FETCH_PERF_CNT_EN`: when defined, adds two outputs, both resetting to 0, incrementing modulo 2^32 and not saturating:
  - `fetch_count` [0:31]: increments on each delivered instruction (`flush` <= 0 transition).
  - `bubble_count` [0:31]: increments on each cycle `flush` is written 1.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

## Structure
- Shared pipeline package holds:
  - the fetch state encoding;
  - bundle field bounds (NEXTPC [0:31], INSTR [32:63]);
  - the PC increment constant 4;
  - the `RESET_PC` default.
- One sub-module, `fetch_perf_cnt`: the two counters, instantiated only under `IF_FETCH_PERF_CNT_EN`.

## Test plan
- Reset, then zero-wait memory returning 32'hAAAA_0000 + address:
  - `imem_addr` sequence is 0, 4, 8;
  - `out` = {4, AAAA_0000}, then {8, AAAA_0004}, with `flush`=0 from cycle 3.
- Memory with 2 wait states: `flush`=1 for 2 cycles between each valid bundle; `imem_addr` stable while waiting.
- `stall` asserted for 3 cycles with a completion during the stall:
  - `out`/`flush` frozen throughout;
  - the held word is delivered the cycle after `stall` drops;
  - no word is lost or duplicated.
- `redirect`=1, `redirect_pc`=32'h0000_0100 while a 2-wait request to 0x10 is outstanding:
  - the 0x10 data is discarded;
  - the next `imem_addr` is 0x100;
  - `out` = {0x104, word@0x100}.
- `redirect` and `stall` together while in HOLD: the held word is discarded, `flush`=1, and the fetch of the target follows.
- PC = 32'hFFFF_FFFC with zero-wait memory: `out`[0:31] = 0; the next `imem_addr` = 0.
